motion_seq: RTL and testbench
=============================

Name: motion_seq

Overview:
- Segment sequencer for the step generator: queues motion segments (start velocity, per-tick acceleration, duration) from the host side and drives the generator's 32-bit velocity input tick by tick.
- Lets the host pre-load trapezoid/ramp profiles so velocity changes with cycle-exact timing.
- Sits between the register/bus interface and one step-generator channel; one instance per axis.

Parameters:
- DEPTH, 8, segment queue depth (power of two, >=2).
- TICK_DIV, 1000, clk cycles per velocity-update tick (>=1).
- VMAX, 32'h3FFFFFFF, magnitude limit applied when saturation is compiled in.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- seg_wr  in  1  push one segment when high (single-cycle strobe).
- seg_vel  in  32  signed start velocity of the segment.
- seg_acc  in  32  signed velocity increment per tick.
- seg_dur  in  16  segment length in ticks; 0 = skip.
- enable  in  1  level; high allows segments to start, low holds IDLE.
- abort  in  1  flush queue, stop immediately.
- velocity  out  32  signed velocity to step generator (registered).
- busy  out  1  high in LOAD or RUN.
- seg_done  out  1  one-cycle pulse when a segment finishes or is skipped.
- underrun  out  1  one-cycle pulse: queue empty at segment end with velocity != 0.
- overflow  out  1  sticky: a write arrived while full; cleared by reset or abort.
- level  out  log2(DEPTH)+1  number of queued segments.
- seg_full  out  1  level == DEPTH.

Behaviour:
- Reset (async): velocity=0, busy=0, seg_done=0, underrun=0, overflow=0, level=0, state IDLE, prescaler=0, queue pointers=0.
- Queue: FIFO of {vel,acc,dur}, 80 bits/entry. A write when full is dropped and sets overflow. A write and a pop in the same cycle are both honoured (level unchanged).
- States:
  - IDLE: velocity held at 0. If enable && level!=0, go LOAD.
  - LOAD (1 cycle): pop head, velocity<=seg_vel, rem<=seg_dur, prescaler<=0.
    - If dur==0: pulse seg_done next cycle, velocity<=0, go LOAD if enable && queue non-empty after the pop, else IDLE.
    - Otherwise go RUN.
  - RUN: prescaler counts 0..TICK_DIV-1. When prescaler==TICK_DIV-1 (tick): velocity<=velocity+acc, rem<=rem-1.
- Segment end: on the tick where rem==1, pulse seg_done.
  - If the queue is non-empty and enable is high: go LOAD; velocity keeps the last value until LOAD overwrites it. The gap between segments is exactly 1 cycle.
  - Else: go IDLE, velocity<=0. Pulse underrun if the final velocity was nonzero.
- Latency: the first velocity appears 2 cycles after seg_wr to an idle, enabled block.
- enable dropping during RUN: the current segment completes; no new LOAD.
- Arithmetic: 32-bit two's complement; wraps on overflow unless saturation is compiled in.
- abort (sync, highest priority): queue emptied, velocity<=0, state IDLE, overflow cleared, no seg_done/underrun pulse. A seg_wr in the same cycle is discarded.
- Reset mid-RUN: immediate return to reset values; no pulses.

Optional Feature:
- Macro MOTION_SEQ_SAT_EN.
- Defined: each tick result and each loaded seg_vel is clamped to [-VMAX, +VMAX]. Overflow past 32 bits is also clamped, detected from the sign of the operands.
- Undefined: plain wrapping add, VMAX unused.

Test Plan:
- Single segment: TICK_DIV=4, push {vel=100, acc=10, dur=3}, enable=1 -> velocity 100, then 110, 120, 130 at 4-cycle spacing. seg_done once; then velocity=0 and underrun pulses.
- Back-to-back: push {0,5,2} and {50,-5,2} -> velocity 0,5,10,50,45,40. Exactly 1 LOAD cycle between segments, two seg_done pulses, final underrun.
- Skip and stop: push {7,0,0} then {0,0,1} -> seg_done for the skip, velocity 0 for 1 tick, then IDLE with no underrun (velocity 0).
- Full queue: DEPTH=8, enable=0, push 9 segments -> level=8, seg_full=1, overflow=1. Abort -> level=0, overflow=0, velocity=0.
- Abort and reset mid-RUN: during RUN with velocity 300, abort -> next cycle velocity=0, busy=0, no pulses. Repeat with async reset asserted off-edge -> outputs zero without waiting for clk.
- Saturation (MOTION_SEQ_SAT_EN, VMAX=1000): push {990, 20, 3} -> velocity 990, 1000, 1000, 1000. Without the macro -> 990, 1010, 1030, 1050.

Source files
------------

// File: rtl/motion_seq_if.sv
// Segment push bus and status bundle between the host register block and one motion_seq axis.
interface motion_seq_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic                 seg_wr;
   logic signed [31:0]   seg_vel;
   logic signed [31:0]   seg_acc;
   logic [15:0]          seg_dur;
   logic                 enable;
   logic                 abort;

   logic signed [31:0]   velocity;
   logic                 busy;
   logic                 seg_done;
   logic                 underrun;
   logic                 overflow;
   logic [LW-1:0]        level;
   logic                 seg_full;

   modport master (
      output seg_wr, seg_vel, seg_acc, seg_dur, enable, abort,
      input  velocity, busy, seg_done, underrun, overflow, level, seg_full
   );

   modport slave (
      input  seg_wr, seg_vel, seg_acc, seg_dur, enable, abort,
      output velocity, busy, seg_done, underrun, overflow, level, seg_full
   );
endinterface

// File: rtl/motion_seq.sv
// Motion segment sequencer: queued {vel, acc, dur} segments drive a tick-by-tick velocity ramp.
// Define MOTION_SEQ_SAT_EN to clamp loaded and accumulated velocity to [-VMAX, +VMAX].
module motion_seq #(
   parameter int unsigned        DEPTH    = 8,
   parameter int unsigned        TICK_DIV = 1000,
   parameter logic signed [31:0] VMAX     = 32'sh3FFFFFFF
) (
   input logic        clk,
   input logic        reset,
   motion_seq_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("motion_seq: DEPTH must be a power of two >= 2");
   end
   if (TICK_DIV < 1) begin : g_bad_tick
      $error("motion_seq: TICK_DIV must be >= 1");
   end
   if (VMAX <= 0) begin : g_bad_vmax
      $error("motion_seq: VMAX must be positive");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN
   } state_e;

   typedef struct packed {
      logic signed [31:0] vel;
      logic signed [31:0] acc;
      logic [15:0]        dur;
   } seg_t;

`ifdef MOTION_SEQ_SAT_EN
   function automatic logic signed [31:0] vel_load(input logic signed [31:0] x);
      if (x > VMAX)
         return VMAX;
      else if (x < -VMAX)
         return -VMAX;
      else
         return x;
   endfunction

   // Wrap past 32 bits is caught from operand/result signs before the range clamp.
   function automatic logic signed [31:0] vel_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      logic signed [31:0] s;
      s = a + b;
      if (!a[31] && !b[31] && s[31])
         return VMAX;
      else if (a[31] && b[31] && !s[31])
         return -VMAX;
      else
         return vel_load(s);
   endfunction
`else
   function automatic logic signed [31:0] vel_load(input logic signed [31:0] x);
      return x;
   endfunction

   function automatic logic signed [31:0] vel_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
      return a + b;
   endfunction
`endif

   seg_t               mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]      level_q, level_d;
   logic               ovf_q;

   state_e             state_q, state_d;
   logic signed [31:0] vel_q, vel_d;
   logic signed [31:0] acc_q, acc_d;
   logic [15:0]        rem_q, rem_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic               done_q, done_d;
   logic               under_q, under_d;

   logic               full;
   logic               push;
   logic               pop;
   logic               wr_drop;
   seg_t               head;

   assign full    = (level_q == LW'(DEPTH));
   assign push    = bus.seg_wr && !full;
   assign wr_drop = bus.seg_wr && full;
   assign head    = mem_q[rd_ptr_q];
   assign level_d = level_q + LW'(push) - LW'(pop);

   always_comb begin
      state_d = state_q;
      vel_d   = vel_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      presc_d = presc_q;
      done_d  = 1'b0;
      under_d = 1'b0;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            vel_d = '0;
            if (bus.enable && level_q != '0)
               state_d = S_LOAD;
         end

         S_LOAD: begin
            pop     = 1'b1;
            presc_d = '0;
            acc_d   = head.acc;
            rem_d   = head.dur;
            if (head.dur == '0) begin
               done_d  = 1'b1;
               vel_d   = '0;
               state_d = (bus.enable && level_q > LW'(1)) ? S_LOAD : S_IDLE;
            end else begin
               vel_d   = vel_load(head.vel);
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (presc_q == PLAST) begin
               presc_d = '0;
               vel_d   = vel_add(vel_q, acc_q);
               rem_d   = rem_q - 16'd1;
               // Final tick: the last value stays visible for one cycle before IDLE zeroes it.
               if (rem_q == 16'd1) begin
                  done_d = 1'b1;
                  if (bus.enable && level_q != '0) begin
                     state_d = S_LOAD;
                  end else begin
                     state_d = S_IDLE;
                     under_d = (vel_d != '0);
                  end
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            vel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         vel_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         presc_q  <= '0;
         done_q   <= 1'b0;
         under_q  <= 1'b0;
         ovf_q    <= 1'b0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (bus.abort) begin
         state_q  <= S_IDLE;
         vel_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         presc_q  <= '0;
         done_q   <= 1'b0;
         under_q  <= 1'b0;
         ovf_q    <= 1'b0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         vel_q    <= vel_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         presc_q  <= presc_d;
         done_q   <= done_d;
         under_q  <= under_d;
         ovf_q    <= ovf_q | wr_drop;
         level_q  <= level_d;
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.abort)
         mem_q[wr_ptr_q] <= {bus.seg_vel, bus.seg_acc, bus.seg_dur};
   end

   assign bus.velocity = vel_q;
   assign bus.busy     = (state_q == S_LOAD) || (state_q == S_RUN);
   assign bus.seg_done = done_q;
   assign bus.underrun = under_q;
   assign bus.overflow = ovf_q;
   assign bus.level    = level_q;
   assign bus.seg_full = full;

endmodule

// File: tb/tb_motion_seq.sv
// Self-checking bench for motion_seq: directed profiles plus randomized traffic against a queue-based model.
module tb_motion_seq;

   localparam int unsigned DEPTH    = 8;
   localparam int unsigned TICK_DIV = 4;
   localparam int          VMAX     = 1000;
   localparam int PH_IDLE = 0;
   localparam int PH_LOAD = 1;
   localparam int PH_RUN  = 2;

   typedef struct {
      int vel;
      int acc;
      int dur;
   } seg_s;

   logic clk = 1'b0;
   logic reset;

   motion_seq_if #(.DEPTH(DEPTH)) bus ();

   motion_seq #(
      .DEPTH    (DEPTH),
      .TICK_DIV (TICK_DIV),
      .VMAX     (32'sd1000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;

   seg_s mq[$];
   seg_s m_cur;
   int   m_phase;
   int   m_k;
   int   m_vel;
   bit   m_done;
   bit   m_under;
   bit   m_ovf;

   int   vseq[$];
   int   exp_q[$];
   int   last_vel;
   int   n_done;
   int   n_under;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

`ifdef MOTION_SEQ_SAT_EN
   function automatic int clampl(input longint x);
      if (x > VMAX) return VMAX;
      if (x < -VMAX) return -VMAX;
      return int'(x);
   endfunction
`endif

   // Velocity of a segment after n ticks.
   function automatic int vel_at(input seg_s s, input int n);
`ifdef MOTION_SEQ_SAT_EN
      int v;
      v = clampl(longint'(s.vel));
      for (int i = 0; i < n; i++)
         v = clampl(longint'(v) + longint'(s.acc));
      return v;
`else
      return s.vel + s.acc * n;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_phase = PH_IDLE;
      m_k     = 0;
      m_vel   = 0;
      m_done  = 1'b0;
      m_under = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step();
      int   size0;
      seg_s s;
      size0   = mq.size();
      m_done  = 1'b0;
      m_under = 1'b0;
      if (bus.abort) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_phase = PH_IDLE;
         m_vel   = 0;
         return;
      end
      case (m_phase)
         PH_IDLE: begin
            m_vel = 0;
            if (bus.enable && size0 > 0) m_phase = PH_LOAD;
         end
         PH_LOAD: begin
            s = mq.pop_front();
            if (s.dur == 0) begin
               m_done  = 1'b1;
               m_vel   = 0;
               m_phase = (bus.enable && mq.size() > 0) ? PH_LOAD : PH_IDLE;
            end else begin
               m_cur   = s;
               m_k     = 0;
               m_vel   = vel_at(s, 0);
               m_phase = PH_RUN;
            end
         end
         default: begin
            m_k++;
            m_vel = vel_at(m_cur, m_k / TICK_DIV);
            if (m_k % TICK_DIV == 0 && m_k / TICK_DIV == m_cur.dur) begin
               m_done = 1'b1;
               if (bus.enable && size0 > 0) begin
                  m_phase = PH_LOAD;
               end else begin
                  m_phase = PH_IDLE;
                  m_under = (m_vel != 0);
               end
            end
         end
      endcase
      if (bus.seg_wr) begin
         if (size0 == DEPTH) m_ovf = 1'b1;
         else mq.push_back('{int'(bus.seg_vel), int'(bus.seg_acc), int'(bus.seg_dur)});
      end
   endtask

   task automatic compare_all();
      chk("velocity", bus.velocity, m_vel);
      chk("busy",     bus.busy,     m_phase != PH_IDLE);
      chk("seg_done", bus.seg_done, m_done);
      chk("underrun", bus.underrun, m_under);
      chk("overflow", bus.overflow, m_ovf);
      chk("level",    bus.level,    mq.size());
      chk("seg_full", bus.seg_full, mq.size() == DEPTH);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (int'(bus.velocity) != last_vel) begin
         last_vel = int'(bus.velocity);
         vseq.push_back(last_vel);
      end
      n_done  += int'(bus.seg_done);
      n_under += int'(bus.underrun);
   endtask

   task automatic start_obs();
      vseq.delete();
      last_vel = int'(bus.velocity);
      n_done   = 0;
      n_under  = 0;
   endtask

   task automatic push(input int v, input int a, input int d);
      bus.seg_wr  = 1'b1;
      bus.seg_vel = v;
      bus.seg_acc = a;
      bus.seg_dur = 16'(d);
      tick();
      bus.seg_wr  = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_vel(input int v, input int budget);
      int n;
      n = 0;
      while (int'(bus.velocity) != v && n < budget) begin
         tick();
         n++;
      end
      chk("wait_vel", bus.velocity, v);
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, vseq.size(), exp_q.size());
      for (int i = 0; i < vseq.size() && i < exp_q.size(); i++)
         chk(tag, vseq[i], exp_q[i]);
   endtask

   initial begin
      reset       = 1'b1;
      bus.seg_wr  = 1'b0;
      bus.seg_vel = '0;
      bus.seg_acc = '0;
      bus.seg_dur = '0;
      bus.enable  = 1'b0;
      bus.abort   = 1'b0;
      model_reset();
      #12;
      compare_all();
      reset      = 1'b0;
      bus.enable = 1'b1;

      // Single segment with 2-cycle first-velocity latency
      start_obs();
      push(100, 10, 3);
      tick();
      chk("lat1", bus.velocity, 0);
      tick();
      chk("lat2", bus.velocity, 100);
      run(20);
      exp_q = {100, 110, 120, 130, 0};
      check_seq("single");
      chk("single_done", n_done, 1);
      chk("single_under", n_under, 1);

      // Back-to-back segments
      start_obs();
      push(0, 5, 2);
      push(50, -5, 2);
      run(30);
      exp_q = {5, 10, 50, 45, 40, 0};
      check_seq("b2b");
      chk("b2b_done", n_done, 2);
      chk("b2b_under", n_under, 1);

      // Skip then zero-velocity stop
      start_obs();
      push(7, 0, 0);
      push(0, 0, 1);
      run(15);
      exp_q.delete();
      check_seq("skip");
      chk("skip_done", n_done, 2);
      chk("skip_under", n_under, 0);

      // Fill past DEPTH, then abort
      bus.enable = 1'b0;
      for (int i = 0; i < 9; i++) push(i * 10, 1, 2);
      chk("full_level", bus.level, 8);
      chk("full_flag", bus.seg_full, 1);
      chk("full_ovf", bus.overflow, 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_level", bus.level, 0);
      chk("abort_ovf", bus.overflow, 0);
      chk("abort_vel", bus.velocity, 0);

      // Abort mid-RUN
      bus.enable = 1'b1;
      push(300, 0, 10);
      wait_vel(300, 20);
      start_obs();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abrun_vel", bus.velocity, 0);
      chk("abrun_busy", bus.busy, 0);
      chk("abrun_pulses", n_done + n_under, 0);
      run(3);

      // Asynchronous reset off-edge mid-RUN
      push(300, 0, 10);
      wait_vel(300, 20);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("areset_vel", bus.velocity, 0);
      chk("areset_busy", bus.busy, 0);
      compare_all();
      reset = 1'b0;
      run(3);

      // Saturation boundary
      start_obs();
      push(990, 20, 3);
      run(20);
`ifdef MOTION_SEQ_SAT_EN
      exp_q = {990, 1000, 0};
`else
      exp_q = {990, 1010, 1030, 1050, 0};
`endif
      check_seq("sat");
      chk("sat_done", n_done, 1);
      chk("sat_under", n_under, 1);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int v;
         int a;
         bus.seg_wr = ($urandom_range(0, 99) < 12);
         v = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
         a = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
         bus.seg_vel = v;
         bus.seg_acc = a;
         bus.seg_dur = 16'($urandom_range(0, 4));
         if ($urandom_range(0, 49) == 0) bus.enable = ~bus.enable;
         bus.abort = ($urandom_range(0, 299) == 0);
         tick();
      end
      bus.seg_wr = 1'b0;
      bus.abort  = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
